// File: rtl/sr_ext_seq_pkg.sv
// Shared definitions for the ALU_EXT launch sequencer: FSM encoding,
// default timeout and the opcode the decoder matches for ALU_EXT.
package sr_ext_seq_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 64;
  localparam logic [6:0] ALU_EXT = 7'b0001011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

  // Counter value at which the last permitted WAIT cycle is reached.
  function automatic logic [7:0] timer_limit(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/sr_ext_timer.sv
// 8-bit saturating cycle counter with synchronous clear, count enable and
// a flag that is high while the count equals LIMIT.
module sr_ext_timer #(
  parameter logic [7:0] LIMIT = 8'd63
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic limit_o
);

  logic [7:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count <= 8'd0;
    end else if (en_i && (count != 8'hff)) begin
      count <= count + 8'd1;
    end
  end

  assign limit_o = (count == LIMIT);

endmodule

// File: rtl/sr_ext_seq.sv
// Sequences one ALU_EXT instruction: latch operands, pulse the ALU start,
// wait for busy to fall (or time out), then write the result back once.
module sr_ext_seq
  import sr_ext_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter bit WB_ON_TIMEOUT  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ext_req_i,
  input  logic [31:0] srcA_i,
  input  logic [31:0] srcB_i,
  input  logic [4:0]  rd_i,
  input  logic        alu_busy_i,
  input  logic [31:0] alu_result_i,
  output logic        alu_start_o,
  output logic [31:0] alu_srcA_o,
  output logic [31:0] alu_srcB_o,
  output logic        alu_ext_sel_o,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        timeout_o,
  output state_t      state_o
);

  state_t      state, state_next;
  logic [31:0] src_a_q, src_b_q, result_q;
  logic [4:0]  rd_q;
  logic        load, capture, clear_result, at_limit, in_flight;

  sr_ext_timer #(
    .LIMIT (timer_limit(TIMEOUT_CYCLES))
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (state == ST_LAUNCH),
    .en_i    (state == ST_WAIT),
    .limit_o (at_limit)
  );

  // A request in IDLE waits while busy is still high: after a reset in WAIT
  // the ALU keeps draining the abandoned operation.
  always_comb begin
    state_next   = state;
    load         = 1'b0;
    capture      = 1'b0;
    clear_result = 1'b0;
    timeout_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ext_req_i && !alu_busy_i) begin
          load       = 1'b1;
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT: begin
        if (!alu_busy_i) begin
          capture    = 1'b1;
          state_next = ST_WRITE;
        end else if (at_limit) begin
          timeout_o    = 1'b1;
          clear_result = 1'b1;
          state_next   = WB_ON_TIMEOUT ? ST_WRITE : ST_IDLE;
        end
      end
      ST_WRITE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      src_a_q  <= 32'd0;
      src_b_q  <= 32'd0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state <= state_next;
      if (load) begin
        src_a_q <= srcA_i;
        src_b_q <= srcB_i;
        rd_q    <= rd_i;
      end
      if (capture) begin
        result_q <= alu_result_i;
      end else if (clear_result) begin
        result_q <= 32'd0;
      end
    end
  end

  assign in_flight     = (state == ST_LAUNCH) || (state == ST_WAIT);
  assign alu_start_o   = (state == ST_LAUNCH);
  assign alu_ext_sel_o = in_flight;
  assign alu_srcA_o    = in_flight ? src_a_q : srcA_i;
  assign alu_srcB_o    = in_flight ? src_b_q : srcB_i;
  // Stall drops in WRITE so the instruction retires on the writeback cycle.
  assign stall_o       = in_flight || ((state == ST_IDLE) && ext_req_i);
  assign wb_valid_o    = (state == ST_WRITE);
  assign wb_rd_o       = wb_valid_o ? rd_q : 5'd0;
  assign wb_data_o     = wb_valid_o ? result_q : 32'd0;
  assign state_o       = state;

endmodule

// File: tb/tb_sr_ext_seq.sv
// Self-checking bench for sr_ext_seq: three instances (default timeout,
// short timeout with and without writeback) share one stimulus.
module tb_sr_ext_seq;
  import sr_ext_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ext_req, busy;
  logic [31:0] src_a, src_b, alu_res;
  logic [4:0]  rd;

  logic        start [3], ext_sel [3], stall [3], wb_valid [3], timeout [3];
  logic [31:0] oa [3], ob [3], wb_data [3];
  logic [4:0]  wb_rd [3];
  state_t      st [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sr_ext_seq u_dut0 (
    .clk_i(clk), .rst_i(rst), .ext_req_i(ext_req), .srcA_i(src_a), .srcB_i(src_b),
    .rd_i(rd), .alu_busy_i(busy), .alu_result_i(alu_res), .alu_start_o(start[0]),
    .alu_srcA_o(oa[0]), .alu_srcB_o(ob[0]), .alu_ext_sel_o(ext_sel[0]), .stall_o(stall[0]),
    .wb_valid_o(wb_valid[0]), .wb_rd_o(wb_rd[0]), .wb_data_o(wb_data[0]),
    .timeout_o(timeout[0]), .state_o(st[0]));

  sr_ext_seq #(.TIMEOUT_CYCLES(8), .WB_ON_TIMEOUT(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .ext_req_i(ext_req), .srcA_i(src_a), .srcB_i(src_b),
    .rd_i(rd), .alu_busy_i(busy), .alu_result_i(alu_res), .alu_start_o(start[1]),
    .alu_srcA_o(oa[1]), .alu_srcB_o(ob[1]), .alu_ext_sel_o(ext_sel[1]), .stall_o(stall[1]),
    .wb_valid_o(wb_valid[1]), .wb_rd_o(wb_rd[1]), .wb_data_o(wb_data[1]),
    .timeout_o(timeout[1]), .state_o(st[1]));

  sr_ext_seq #(.TIMEOUT_CYCLES(8), .WB_ON_TIMEOUT(1'b0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .ext_req_i(ext_req), .srcA_i(src_a), .srcB_i(src_b),
    .rd_i(rd), .alu_busy_i(busy), .alu_result_i(alu_res), .alu_start_o(start[2]),
    .alu_srcA_o(oa[2]), .alu_srcB_o(ob[2]), .alu_ext_sel_o(ext_sel[2]), .stall_o(stall[2]),
    .wb_valid_o(wb_valid[2]), .wb_rd_o(wb_rd[2]), .wb_data_o(wb_data[2]),
    .timeout_o(timeout[2]), .state_o(st[2]));

  typedef struct {
    logic        ext_req;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ext_req = 1'b0; busy = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // One operation on instance d; cycle k=0 is the IDLE acceptance cycle.
  // The ALU model raises busy from the first WAIT cycle for nbusy cycles.
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input int nbusy, input logic [31:0] res,
                        input int ncyc, output int wb_cyc, output logic [31:0] wd,
                        output logic [4:0] wr, output int n_wb, output int n_start,
                        output int n_stall, output int n_sel, output int to_cyc,
                        output int n_to, output int src_bad);
    wb_cyc = -1; wd = '0; wr = '0; n_wb = 0; n_start = 0; n_stall = 0; n_sel = 0;
    to_cyc = -1; n_to = 0; src_bad = 0;
    for (int k = 0; k < ncyc; k++) begin
      ext_req = (k == 0) || (k == 3);
      src_a   = (k == 0) ? a : (a ^ 32'hffff_0000 ^ 32'(k));
      src_b   = (k == 0) ? b : (b ^ 32'h0f0f_0000 ^ 32'(k));
      rd      = (k == 0) ? r : (r ^ 5'h1f);
      busy    = (k >= 2) && (k < 2 + nbusy);
      alu_res = busy ? 32'hdead_beef : res;
      #1;
      if (start[d]) n_start++;
      if (stall[d] && k >= 1) n_stall++;
      if (ext_sel[d]) begin
        n_sel++;
        if (oa[d] !== a || ob[d] !== b) src_bad++;
      end
      if (wb_valid[d]) begin
        n_wb++; wb_cyc = k; wd = wb_data[d]; wr = wb_rd[d];
        if (oa[d] !== src_a || ob[d] !== src_b || stall[d] !== 1'b0) src_bad++;
      end
      if (timeout[d]) begin
        n_to++; to_cyc = k;
      end
      step();
    end
    ext_req = 1'b0; busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc, nw, ns, nst, nsl, tc, nt, sb, i;
    logic [31:0] wd;
    logic [4:0]  wr;
    int starts;

    rst = 1'b1; ext_req = 1'b0; busy = 1'b0;
    src_a = '0; src_b = '0; rd = '0; alu_res = '0;
    vecs[0] = '{1'b0, 32'd0,          32'd0,          1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'd27,         32'd16,         1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'hffff_ffff,  32'h8000_0001,  1'b1, 1'b1};
    vecs[3] = '{1'b0, 32'h1234_5678,  32'h9abc_def0,  1'b1, 1'b0};
    repeat (2) step();

    // Held in reset: IDLE pass-through and combinational stall.
    for (int v = 0; v < 4; v++) begin
      ext_req = vecs[v].ext_req; src_a = vecs[v].a; src_b = vecs[v].b; busy = vecs[v].busy;
      #1;
      for (int d = 0; d < 3; d++) begin
        check($sformatf("vec%0d_dut%0d_stall", v, d), 32'(stall[d]), 32'(vecs[v].exp_stall));
        check($sformatf("vec%0d_dut%0d_srca", v, d), oa[d], vecs[v].a);
        check($sformatf("vec%0d_dut%0d_srcb", v, d), ob[d], vecs[v].b);
      end
      step();
    end
    ext_req = 1'b0; busy = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_dut%0d_state", d), 32'(st[d]), 32'(ST_IDLE));
      check($sformatf("rst_dut%0d_outs", d),
            {20'd0, start[d], ext_sel[d], wb_valid[d], timeout[d], stall[d], 2'd0, wb_rd[d]}, 32'd0);
      check($sformatf("rst_dut%0d_wbdata", d), wb_data[d], 32'd0);
    end

    // Nominal operation: busy 10 cycles, result 7.
    do_reset();
    run_op(0, 32'd27, 32'd16, 5'd5, 10, 32'd7, 14, wc, wd, wr, nw, ns, nst, nsl, tc, nt, sb);
    check("nom_starts", 32'(ns), 32'd1);
    check("nom_stall", 32'(nst), 32'd12);
    check("nom_extsel", 32'(nsl), 32'd12);
    check("nom_wbcyc", 32'(wc), 32'd13);
    check("nom_nwb", 32'(nw), 32'd1);
    check("nom_data", wd, 32'd7);
    check("nom_rd", 32'(wr), 32'd5);
    check("nom_timeout", 32'(nt), 32'd0);
    check("nom_src_latched", 32'(sb), 32'd0);

    // Busy never falls, TIMEOUT_CYCLES=8, with writeback.
    do_reset();
    run_op(1, 32'd3, 32'd4, 5'd9, 100, 32'd55, 12, wc, wd, wr, nw, ns, nst, nsl, tc, nt, sb);
    check("to_wb_ntimeout", 32'(nt), 32'd1);
    check("to_wb_tocyc", 32'(tc), 32'd9);
    check("to_wb_wbcyc", 32'(wc), 32'd10);
    check("to_wb_data", wd, 32'd0);
    check("to_wb_rd", 32'(wr), 32'd9);

    // Same, writeback dropped.
    do_reset();
    run_op(2, 32'd3, 32'd4, 5'd9, 100, 32'd55, 12, wc, wd, wr, nw, ns, nst, nsl, tc, nt, sb);
    check("to_nowb_ntimeout", 32'(nt), 32'd1);
    check("to_nowb_tocyc", 32'(tc), 32'd9);
    check("to_nowb_nwb", 32'(nw), 32'd0);
    check("to_nowb_state", 32'(st[2]), 32'(ST_IDLE));

    // Busy falls on the limit cycle: real result wins.
    do_reset();
    run_op(1, 32'd5, 32'd6, 5'd2, 7, 32'h0000_abcd, 12, wc, wd, wr, nw, ns, nst, nsl, tc, nt, sb);
    check("lim_wb_timeout", 32'(nt), 32'd0);
    check("lim_wb_wbcyc", 32'(wc), 32'd10);
    check("lim_wb_data", wd, 32'h0000_abcd);
    do_reset();
    run_op(2, 32'd5, 32'd6, 5'd0, 7, 32'h0000_1234, 12, wc, wd, wr, nw, ns, nst, nsl, tc, nt, sb);
    check("lim_nowb_timeout", 32'(nt), 32'd0);
    check("lim_nowb_nwb", 32'(nw), 32'd1);
    check("lim_nowb_data", wd, 32'h0000_1234);
    check("lim_nowb_rd0", 32'(wr), 32'd0);

    // Back-to-back: second request accepted the IDLE cycle after WRITE.
    do_reset();
    run_op(0, 32'd64, 32'd9, 5'd3, 3, 32'd7, 7, wc, wd, wr, nw, ns, nst, nsl, tc, nt, sb);
    check("b2b1_wbcyc", 32'(wc), 32'd6);
    check("b2b1_data", wd, 32'd7);
    check("b2b1_rd", 32'(wr), 32'd3);
    check("b2b1_src", 32'(sb), 32'd0);
    run_op(0, 32'd8, 32'd4, 5'd4, 2, 32'd4, 6, wc, wd, wr, nw, ns, nst, nsl, tc, nt, sb);
    check("b2b2_starts", 32'(ns), 32'd1);
    check("b2b2_wbcyc", 32'(wc), 32'd5);
    check("b2b2_data", wd, 32'd4);
    check("b2b2_rd", 32'(wr), 32'd4);
    check("b2b2_src", 32'(sb), 32'd0);

    // Reset in the 3rd WAIT cycle, then a request while the ALU drains.
    do_reset();
    ext_req = 1'b1; src_a = 32'd11; src_b = 32'd22; rd = 5'd7; busy = 1'b0;
    step();
    ext_req = 1'b0;
    #1;
    check("rw_launch_start", 32'(start[0]), 32'd1);
    busy = 1'b1;
    step();
    step();
    step();
    check("rw_wait3_state", 32'(st[0]), 32'(ST_WAIT));
    rst = 1'b1;
    step();
    rst = 1'b0; ext_req = 1'b1; src_a = 32'd33; src_b = 32'd44; rd = 5'd8;
    #1;
    check("rw_after_state", 32'(st[0]), 32'(ST_IDLE));
    check("rw_after_outs", {29'd0, wb_valid[0], timeout[0], start[0]}, 32'd0);
    check("rw_after_stall", 32'(stall[0]), 32'd1);
    starts = 0;
    for (i = 0; i < 3; i++) begin
      step();
      #1;
      if (start[0] || st[0] != ST_IDLE) starts++;
    end
    check("rw_held_idle", 32'(starts), 32'd0);
    busy = 1'b0;
    step();
    ext_req = 1'b0; alu_res = 32'd99;
    #1;
    check("rw_new_start", 32'(start[0]), 32'd1);
    check("rw_new_srca", oa[0], 32'd33);
    step();
    step();
    #1;
    check("rw_new_wbvalid", 32'(wb_valid[0]), 32'd1);
    check("rw_new_data", wb_data[0], 32'd99);
    check("rw_new_rd", 32'(wb_rd[0]), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
